// File: rtl/vector_register_reader_if.sv
// Element stream from the vector register reader to a scalar consumer.
// The reader drives the element fields; the consumer answers with elem_ready.
interface vector_register_reader_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LANES = 2
);
   localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [WIDTH-1:0] elem_out;
   logic [IDXW-1:0]  elem_idx;
   logic             elem_valid;
   logic             elem_ready;
   logic             elem_last;

   modport master (
      output elem_out,
      output elem_idx,
      output elem_valid,
      output elem_last,
      input  elem_ready
   );

   modport slave (
      input  elem_out,
      input  elem_idx,
      input  elem_valid,
      input  elem_last,
      output elem_ready
   );
endinterface

// File: rtl/vector_register_reader.sv
// Snapshots a packed vector on start and streams it one element per handshake.
// Define VECTOR_READER_REVERSE_EN to stream from lane LANES-1 down to lane 0.
module vector_register_reader #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LANES = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [LANES-1:0][WIDTH-1:0] vec_in,
   output logic                        busy,
   output logic                        done,
   vector_register_reader_if.master    stream
);
   localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;

`ifdef VECTOR_READER_REVERSE_EN
   localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(LANES - 1);
   localparam logic [IDXW-1:0] END_IDX   = IDXW'(0);
`else
   localparam logic [IDXW-1:0] FIRST_IDX = IDXW'(0);
   localparam logic [IDXW-1:0] END_IDX   = IDXW'(LANES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [LANES-1:0][WIDTH-1:0] snap_q, snap_d;
   logic [IDXW-1:0]             idx_q, idx_d;
   logic                        busy_d, done_d, valid_d, last_d;
   logic [WIDTH-1:0]            out_d;
   logic [IDXW-1:0]             eidx_d;

   // State, snapshot and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         snap_q            <= '0;
         idx_q             <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         stream.elem_valid <= 1'b0;
         stream.elem_last  <= 1'b0;
         stream.elem_out   <= '0;
         stream.elem_idx   <= '0;
      end else begin
         state_q           <= state_d;
         snap_q            <= snap_d;
         idx_q             <= idx_d;
         busy              <= busy_d;
         done              <= done_d;
         stream.elem_valid <= valid_d;
         stream.elem_last  <= last_d;
         stream.elem_out   <= out_d;
         stream.elem_idx   <= eidx_d;
      end
   end

   // Next state and next output values; element fields hold unless a handshake occurs
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      idx_d   = idx_q;
      busy_d  = busy;
      done_d  = 1'b0;
      valid_d = stream.elem_valid;
      last_d  = stream.elem_last;
      out_d   = stream.elem_out;
      eidx_d  = stream.elem_idx;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SEND;
               snap_d  = vec_in;
               idx_d   = FIRST_IDX;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               out_d   = vec_in[FIRST_IDX];
               eidx_d  = FIRST_IDX;
               last_d  = (FIRST_IDX == END_IDX);
            end
         end
         SEND: begin
            if (stream.elem_ready) begin
               if (idx_q == END_IDX) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  out_d   = '0;
                  eidx_d  = '0;
               end else begin
`ifdef VECTOR_READER_REVERSE_EN
                  idx_d = idx_q - IDXW'(1);
`else
                  idx_d = idx_q + IDXW'(1);
`endif
                  out_d  = snap_q[idx_d];
                  eidx_d = idx_d;
                  last_d = (idx_d == END_IDX);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            out_d   = '0;
            eidx_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_vector_register_reader.sv
// Directed bench for vector_register_reader with a scoreboard of expected elements.
module tb_vector_register_reader;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned LANES = 2;
   localparam int unsigned IDXW  = (LANES > 1) ? $clog2(LANES) : 1;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [IDXW-1:0]  idx;
      logic             last;
   } elem_t;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        start;
   logic [LANES-1:0][WIDTH-1:0] vec_in;
   logic                        busy;
   logic                        done;

   vector_register_reader_if #(.WIDTH(WIDTH), .LANES(LANES)) u_if ();

   vector_register_reader #(.WIDTH(WIDTH), .LANES(LANES)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .vec_in (vec_in),
      .busy   (busy),
      .done   (done),
      .stream (u_if.master)
   );

   always #5 clk = ~clk;

   elem_t q[$];
   int    checks   = 0;
   int    passed   = 0;
   int    done_cnt = 0;
   int    n_cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Expected stream order for one snapshot
   task automatic push_vec(input logic [LANES-1:0][WIDTH-1:0] v);
      elem_t e;
      int    lane;
      for (int i = 0; i < LANES; i++) begin
`ifdef VECTOR_READER_REVERSE_EN
         lane = LANES - 1 - i;
`else
         lane = i;
`endif
         e.data = v[lane];
         e.idx  = IDXW'(lane);
         e.last = (i == LANES - 1);
         q.push_back(e);
      end
   endtask

   // One clock: monitor at negedge, then step past the rising edge
   task automatic cycle();
      elem_t e;
      @(negedge clk);
      n_cyc++;
      if (done) begin
         done_cnt++;
         chk("done_busy", 32'(busy), 32'd0);
         chk("done_valid", 32'(u_if.elem_valid), 32'd0);
      end
      if (u_if.elem_valid && u_if.elem_ready) begin
         checks++;
         assert (q.size() != 0) passed++;
         else $error("FAIL unexpected_elem observed=%0h expected=none", u_if.elem_out);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("elem_out", 32'(u_if.elem_out), 32'(e.data));
            chk("elem_idx", 32'(u_if.elem_idx), 32'(e.idx));
            chk("elem_last", 32'(u_if.elem_last), 32'(e.last));
            chk("busy_send", 32'(busy), 32'd1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, input int exp_cycles);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         cycle();
         n++;
      end
      chk("done_latency", 32'(n), 32'(exp_cycles));
      cycle();
      chk("done_one_cycle", 32'(done_cnt), 32'(d0 + 1));
      chk("queue_drained", 32'(q.size()), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_valid"}, 32'(u_if.elem_valid), 32'd0);
      chk({tag, "_last"}, 32'(u_if.elem_last), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_out"}, 32'(u_if.elem_out), 32'd0);
      chk({tag, "_idx"}, 32'(u_if.elem_idx), 32'd0);
   endtask

   initial begin
      int d0;
      rst             = 1'b1;
      start           = 1'b0;
      vec_in          = '0;
      u_if.elem_ready = 1'b0;
      cycle();
      cycle();
      check_idle_outputs("reset");
      rst = 1'b0;
      cycle();

      // Basic stream, ready held high
      u_if.elem_ready = 1'b1;
      vec_in = {4'b1100, 4'b1010};
      start  = 1'b1;
      push_vec(vec_in);
      cycle();
      start = 1'b0;
      chk("first_valid", 32'(u_if.elem_valid), 32'd1);
      wait_done(20, LANES + 1);
      check_idle_outputs("after_done");

      // Backpressure for three cycles on the first element
      u_if.elem_ready = 1'b0;
      start = 1'b1;
      push_vec(vec_in);
      cycle();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_out", 32'(u_if.elem_out), 32'(q[0].data));
         chk("stall_idx", 32'(u_if.elem_idx), 32'(q[0].idx));
         chk("stall_valid", 32'(u_if.elem_valid), 32'd1);
         cycle();
      end
      u_if.elem_ready = 1'b1;
      wait_done(20, LANES + 1);

      // vec_in changes after capture do not reach the stream
      vec_in = {4'b1100, 4'b1010};
      start  = 1'b1;
      push_vec(vec_in);
      cycle();
      start  = 1'b0;
      vec_in = {4'b1111, 4'b0000};
      wait_done(20, LANES + 1);

      // start held while busy is ignored
      vec_in = {4'b1100, 4'b1010};
      start  = 1'b1;
      push_vec(vec_in);
      cycle();
      vec_in = {4'b1111, 4'b0000};
      cycle();
      cycle();
      start = 1'b0;
      wait_done(20, 1);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("idle_valid", 32'(u_if.elem_valid), 32'd0);
      end

      // Reset during the second element discards it with no done
      vec_in = {4'b1100, 4'b1010};
      start  = 1'b1;
      push_vec(vec_in);
      cycle();
      start = 1'b0;
      cycle();
      chk("second_valid", 32'(u_if.elem_valid), 32'd1);
      rst             = 1'b1;
      u_if.elem_ready = 1'b0;
      d0              = done_cnt;
      cycle();
      check_idle_outputs("mid_reset");
      rst = 1'b0;
      q.delete();
      for (int k = 0; k < 3; k++) cycle();
      chk("no_done_after_reset", 32'(done_cnt), 32'(d0));

      u_if.elem_ready = 1'b1;
      vec_in = {4'b0011, 4'b0101};
      start  = 1'b1;
      push_vec(vec_in);
      cycle();
      start = 1'b0;
      wait_done(20, LANES + 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/vector_register_reader.md
# vector_register_reader

Read-side companion of the vector register. Snapshots a packed vector (LANES elements of WIDTH bits) on a start pulse, then streams it out one element per cycle over a valid/ready handshake to a scalar consumer (lane ALU, store unit, debug port). Completion is signalled by a last flag on the final element and a one-cycle done pulse. It is the counterpart of the parallel-load write path: one side loads a whole vector at once, this block drains it element by element.

## Interface
- WIDTH, 4, bits per element
- LANES, 2, elements per vector (≥1)
- IDXW, LANES>1 ? $clog2(LANES) : 1, element index width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to read vec_in; accepted only in IDLE
- vec_in  in  [LANES-1:0][WIDTH-1:0]  source vector (packed, element 0 = bits [WIDTH-1:0])
- busy  out  1  high while a snapshot is being streamed (state SEND)
- elem_out  out  WIDTH  current element
- elem_idx  out  IDXW  lane index of elem_out
- elem_valid  out  1  elem_out/elem_idx/elem_last are valid
- elem_ready  in  1  consumer accepts element this cycle
- elem_last  out  1  current element is the final one
- done  out  1  one-cycle pulse after the last element is accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: busy=0, elem_valid=0. On start=1: capture vec_in into internal snapshot, load index counter with first lane, go to SEND.
- SEND: busy=1, elem_valid=1, elem_out=snapshot[idx], elem_idx=idx, elem_last=(idx==last lane).
  - Handshake = elem_valid & elem_ready. Without handshake all element outputs hold stable.
  - Handshake and not last: advance idx by one lane, stay in SEND.
  - Handshake and last: go to DONE.
- DONE: done=1, busy=0, elem_valid=0 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while in SEND is ignored; snapshot is not modified.
- vec_in changes after the capture cycle have no effect on the stream.
- LANES=1: single element, elem_last=1 on first SEND cycle.
- Index never wraps: counter stops at last lane; DONE always follows last handshake.
- Element order: lane 0 first up to lane LANES-1 (default; see Configuration).

## Timing
- Reset (rst=1 at clock edge): state=IDLE, snapshot=0, idx=0; busy=0, elem_valid=0, elem_last=0, done=0, elem_out=0, elem_idx=0. Reset takes priority over start and handshakes; applies mid-stream, discarding remaining elements with no done pulse.
- start sampled at edge N → elem_valid=1 with first element from edge N (visible in cycle N+1).
- With elem_ready held high: one element per cycle; LANES cycles in SEND, done in cycle N+LANES+1; earliest next start accepted at edge after DONE (cycle N+LANES+2 sample).
- Outputs are registered/decoded from registered state only; no combinational path from elem_ready or start to any output.
- Backpressure: elem_ready low for k cycles extends SEND by k cycles, nothing lost or duplicated.

## Configuration
- Macro VECTOR_READER_REVERSE_EN.
- Defined: stream order reversed—first element is lane LANES-1, counter decrements, elem_last when idx==0; elem_idx still reports true lane number.
- Undefined: lane 0 first, incrementing, elem_last when idx==LANES-1.
- Reset values, handshake and latency identical in both builds.

## Test plan
- WIDTH=4, LANES=2, vec_in={4'b1100,4'b1010}, start 1 cycle, elem_ready=1 → elem 4'b1010 idx0 last0, then 4'b1100 idx1 last1, then done=1 one cycle, busy 0.
- Same snapshot, elem_ready=0 for 3 cycles in SEND → elem_out stays 4'b1010/idx0 for 3 cycles; then both elements delivered exactly once.
- After start, change vec_in to {4'b1111,4'b0000} → stream still 4'b1010, 4'b1100.
- Pulse start again while busy → ignored; exactly 2 elements and one done pulse.
- rst=1 during second element → next cycle all outputs 0, state IDLE, no done; new start with {4'b0011,4'b0101} streams 4'b0101, 4'b0011.
- With VECTOR_READER_REVERSE_EN defined, vec_in={4'b1100,4'b1010} → 4'b1100 idx1 last0, then 4'b1010 idx0 last1, done.
